v68k_bus_ctrl: RTL

//  68000-style asynchronous bus master between the core sequencer and the external bus.

---
 rtl/v68k_bus_pkg.sv | 31 +++
 rtl/v68k_bus_timer.sv | 31 +++
 rtl/v68k_bus_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/v68k_bus_pkg.sv
// Shared encodings for the 68000-style bus master: sizes, status codes, strobe levels, FSM states.
package v68k_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BERR    = 2'b01;
  localparam logic [1:0] ST_ADDRERR = 2'b10;

  localparam logic DS_ON     = 1'b0;
  localparam logic DS_OFF    = 1'b1;
  localparam logic AS_STROBE = 1'b0;
  localparam logic AS_OFF    = 1'b1;
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StBus     = 2'b01,
    StRecover = 2'b10
  } bus_state_e;

  // Returns {UDS, LDS}: even byte lives on the upper lane.
  function automatic logic [1:0] ds_sel(input logic [1:0] size, input logic a0);
    if (size != SZ_BYTE) return {DS_ON, DS_ON};
    return a0 ? {DS_OFF, DS_ON} : {DS_ON, DS_OFF};
  endfunction

endpackage

// File: rtl/v68k_bus_timer.sv
// Loadable down-counter used for wait states and the optional bus timeout.
module v68k_bus_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/v68k_bus_ctrl.sv
// 68000-style bus master: one byte/word/long request as one or two 16-bit AS/UDS/LDS cycles.
// Define V68K_BUS_TIMEOUT_EN to turn a missing DTACK into a synthetic bus error after TIMEOUT cycles.
module v68k_bus_ctrl
  import v68k_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_fc,
  output logic              done,
  output logic [1:0]        status,
  output logic [31:0]       rdata,
  output logic [ADDR_W-2:0] A,
  output logic              AS,
  output logic              UDS,
  output logic              LDS,
  output logic              RW,
  output logic [2:0]        FC,
  output logic [15:0]       d_out,
  output logic              d_oe,
  input  logic [15:0]       D_in,
  input  logic              DTACK,
  input  logic              BERR
);

  // One counter width covers both the 0..15 wait states and the timeout range.
  localparam int unsigned TimerW = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;

  bus_state_e        state_q, state_d;
  logic [ADDR_W-2:0] a_q, a_d;
  logic              as_q, as_d, uds_q, uds_d, lds_q, lds_d;
  logic              rw_q, rw_d;
  logic [2:0]        fc_q, fc_d;
  logic [15:0]       dout_q, dout_d;
  logic [15:0]       wlo_q, wlo_d;
  logic              long_q, long_d, second_q, second_d;
  logic              byte_q, byte_d, odd_q, odd_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [31:0]       rdata_q, rdata_d;

  logic timer_load, wait_dec, wait_exp, timeout_hit, bus_err;
  logic is_byte, is_long;

  assign is_byte = (req_size == SZ_BYTE);
  assign is_long = (req_size == SZ_LONG);

  v68k_bus_timer #(.W(TimerW)) u_wait (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .load_i    (timer_load),
    .load_val_i(TimerW'(WAIT_STATES)),
    .dec_i     (wait_dec),
    .expired_o (wait_exp)
  );

`ifdef V68K_BUS_TIMEOUT_EN
  logic to_exp;

  v68k_bus_timer #(.W(TimerW)) u_timeout (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .load_i    (timer_load),
    .load_val_i(TimerW'(TIMEOUT - 1)),
    .dec_i     ((state_q == StBus) && wait_exp && !DTACK && !BERR),
    .expired_o (to_exp)
  );

  assign timeout_hit = to_exp;
`else
  assign timeout_hit = 1'b0;
`endif

  // BERR wins over DTACK; a timeout only counts when neither arrived.
  assign bus_err = BERR || (!DTACK && timeout_hit);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    as_d       = as_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    rw_d       = rw_q;
    fc_d       = fc_q;
    dout_d     = dout_q;
    wlo_d      = wlo_q;
    long_d     = long_q;
    second_d   = second_q;
    byte_d     = byte_q;
    odd_d      = odd_q;
    done_d     = 1'b0;
    status_d   = status_q;
    rdata_d    = rdata_q;
    timer_load = 1'b0;
    wait_dec   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!is_byte && req_addr[0]) begin
            done_d   = 1'b1;
            status_d = ST_ADDRERR;
          end else begin
            a_d            = req_addr[ADDR_W-1:1];
            rw_d           = req_rw;
            fc_d           = req_fc;
            as_d           = AS_STROBE;
            {uds_d, lds_d} = ds_sel(req_size, req_addr[0]);
            if (is_byte)      dout_d = {2{req_wdata[7:0]}};
            else if (is_long) dout_d = req_wdata[31:16];
            else              dout_d = req_wdata[15:0];
            wlo_d      = req_wdata[15:0];
            long_d     = is_long;
            second_d   = 1'b0;
            byte_d     = is_byte;
            odd_d      = req_addr[0];
            status_d   = ST_OK;
            timer_load = 1'b1;
            state_d    = StBus;
          end
        end
      end
      StBus: begin
        if (!wait_exp) begin
          wait_dec = 1'b1;
        end else if (bus_err) begin
          {as_d, uds_d, lds_d} = {AS_OFF, DS_OFF, DS_OFF};
          status_d = ST_BERR;
          long_d   = 1'b0;
          state_d  = StRecover;
        end else if (DTACK) begin
          {as_d, uds_d, lds_d} = {AS_OFF, DS_OFF, DS_OFF};
          if (byte_q)        rdata_d = {24'h0, odd_q ? D_in[7:0] : D_in[15:8]};
          else if (!long_q)  rdata_d = {16'h0, D_in};
          else if (!second_q) rdata_d = {D_in, 16'h0};
          else               rdata_d = {rdata_q[31:16], D_in};
          state_d = StRecover;
        end
      end
      StRecover: begin
        if (long_q && !second_q) begin
          a_d        = a_q + 1'b1;
          dout_d     = wlo_q;
          second_d   = 1'b1;
          {as_d, uds_d, lds_d} = {AS_STROBE, DS_ON, DS_ON};
          timer_load = 1'b1;
          state_d    = StBus;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      a_q      <= '0;
      as_q     <= AS_OFF;
      uds_q    <= DS_OFF;
      lds_q    <= DS_OFF;
      rw_q     <= RW_READ;
      fc_q     <= '0;
      dout_q   <= '0;
      wlo_q    <= '0;
      long_q   <= 1'b0;
      second_q <= 1'b0;
      byte_q   <= 1'b0;
      odd_q    <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      as_q     <= as_d;
      uds_q    <= uds_d;
      lds_q    <= lds_d;
      rw_q     <= rw_d;
      fc_q     <= fc_d;
      dout_q   <= dout_d;
      wlo_q    <= wlo_d;
      long_q   <= long_d;
      second_q <= second_d;
      byte_q   <= byte_d;
      odd_q    <= odd_d;
      done_q   <= done_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign done      = done_q;
  assign status    = status_q;
  assign rdata     = rdata_q;
  assign A         = a_q;
  assign AS        = as_q;
  assign UDS       = uds_q;
  assign LDS       = lds_q;
  assign RW        = rw_q;
  assign FC        = fc_q;
  assign d_out     = dout_q;
  assign d_oe      = (state_q == StBus) && (rw_q == RW_WRITE);

endmodule
